// File: rtl/axi_burst_rd2ram.sv
// AXI4 read master that copies a run of data beats from DDR into an on-chip
// buffer RAM. The transfer is cut into INCR bursts of at most C_MAX_BURST beats
// that never cross a 4 KB page. Completion is reported with ap_ctrl_hs style
// handshake pulses, and a sticky error flag records protocol problems.
//
// Handshakes: an AXI channel transfers a beat on a rising edge where both
// valid and ready are high; this block holds arvalid/araddr/arlen stable until
// arready, and keeps rready high for the whole R phase of a burst.
module axi_burst_rd2ram #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_LEN_WIDTH  = 8,
    parameter int C_MAX_BURST        = 16,
    parameter int C_RAM_ADDR_WIDTH   = 10
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    output logic                          O_ap_idle,
    output logic                          O_ap_ready,
    output logic                          O_err,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_ram_base,
    input  logic [C_RAM_ADDR_WIDTH:0]     I_len,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] O_wdata,
    output logic                          O_wr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
    output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen,
    output logic [2:0]                    O_maxi_arsize,
    output logic [1:0]                    O_maxi_arburst,
    output logic                          O_maxi_arvalid,
    input  logic                          I_maxi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
    input  logic [1:0]                    I_maxi_rresp,
    input  logic                          I_maxi_rlast,
    input  logic                          I_maxi_rvalid,
    output logic                          O_maxi_rready
);

    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int DW     = C_M_AXI_DATA_WIDTH;
    localparam int LW     = C_M_AXI_LEN_WIDTH;
    localparam int RAW    = C_RAM_ADDR_WIDTH;
    localparam int CW     = RAW + 1;
    localparam int BYTES  = DW / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int BW     = $clog2(C_MAX_BURST) + 1;
    localparam logic [31:0] MAX_U = C_MAX_BURST;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Transfer bookkeeping
    logic [AW-1:0]  addr;        // DDR address of the next burst to issue
    logic [CW-1:0]  remaining;   // beats not yet covered by an issued burst
    logic [RAW-1:0] ram_base_q;  // latched first RAM word address
    logic [CW-1:0]  burst_idx;   // transfer beat index of the current burst's first beat
    logic [BW-1:0]  burst_len;   // beats in the current burst
    logic [BW-1:0]  beat_cnt;    // beats received so far in the current burst

    // Burst sizing
    logic [31:0]    page_beats;
    logic [31:0]    size_ext;
    logic [BW-1:0]  burst_size;

    // Read-channel events
    logic           beat_fire;
    logic           last_expected;
    logic           burst_end;

    assign O_maxi_arsize  = 3'(BSHIFT);
    assign O_maxi_arburst = 2'b01;

    // Size of the next burst: limited by remaining beats, the burst cap and the 4 KB page end
    always_comb begin
        page_beats = (32'd4096 - {20'd0, addr[11:0]}) >> BSHIFT;
        size_ext   = 32'(remaining);
        if (size_ext > MAX_U) begin
            size_ext = MAX_U;
        end
        if (size_ext > page_beats) begin
            size_ext = page_beats;
        end
        burst_size = BW'(size_ext);
    end

    // Beat acceptance and end-of-burst detection (count or an early rlast ends the burst)
    always_comb begin
        beat_fire     = (state == S_R) && I_maxi_rvalid;
        last_expected = (beat_cnt == (burst_len - BW'(1)));
        burst_end     = beat_fire && (last_expected || I_maxi_rlast);
    end

    // State register
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (I_ap_start) begin
                    next_state = (I_len == '0) ? S_DONE : S_AR;
                end
            end
            S_AR: begin
                if (O_maxi_arvalid && I_maxi_arready) begin
                    next_state = S_R;
                end
            end
            S_R: begin
                if (burst_end) begin
                    next_state = (remaining != '0) ? S_AR : S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        O_ap_idle     = (state == S_IDLE);
        O_ap_done     = (state == S_DONE);
        O_ap_ready    = (state == S_DONE);
        O_maxi_rready = (state == S_R);
    end

    // Datapath: latch the job, issue bursts, forward beats to the RAM, track errors
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            addr           <= '0;
            remaining      <= '0;
            ram_base_q     <= '0;
            burst_idx      <= '0;
            burst_len      <= '0;
            beat_cnt       <= '0;
            O_maxi_arvalid <= 1'b0;
            O_maxi_araddr  <= '0;
            O_maxi_arlen   <= '0;
            O_wr           <= 1'b0;
            O_waddr        <= '0;
            O_wdata        <= '0;
            O_err          <= 1'b0;
        end else begin
            O_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_ap_start) begin
                        addr       <= I_base_addr;
                        remaining  <= I_len;
                        ram_base_q <= I_ram_base;
                        burst_idx  <= '0;
                        O_err      <= 1'b0;
                    end
                end
                S_AR: begin
                    if (!O_maxi_arvalid) begin
                        // First AR cycle: size the burst and present it from the next cycle
                        O_maxi_arvalid <= 1'b1;
                        O_maxi_araddr  <= addr;
                        O_maxi_arlen   <= LW'(burst_size - BW'(1));
                        addr           <= addr + AW'(32'(burst_size) << BSHIFT);
                        remaining      <= remaining - CW'(burst_size);
                        burst_len      <= burst_size;
                        beat_cnt       <= '0;
                    end else if (I_maxi_arready) begin
                        O_maxi_arvalid <= 1'b0;
                    end
                end
                S_R: begin
                    if (beat_fire) begin
                        O_wr     <= 1'b1;
                        O_wdata  <= I_maxi_rdata;
                        O_waddr  <= ram_base_q + RAW'(burst_idx) + RAW'(beat_cnt);
                        beat_cnt <= beat_cnt + BW'(1);
                        if ((I_maxi_rresp != 2'b00) ||
                            (I_maxi_rlast && !last_expected) ||
                            (last_expected && !I_maxi_rlast)) begin
                            O_err <= 1'b1;
                        end
                        // Beats cut off by an early rlast still count, so RAM placement stays aligned
                        if (burst_end) begin
                            burst_idx <= burst_idx + CW'(burst_len);
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_rd2ram.sv
// Bench for axi_burst_rd2ram: a randomised AXI slave feeds the engine while a
// page/burst model predicts the AR sequence and a RAM-placement model predicts
// every RAM write; one compare process checks writes and AR stability each cycle.
module tb_axi_burst_rd2ram;

    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int LW  = 8;
    localparam int RAW = 10;
    localparam int CW  = RAW + 1;

    logic           clk;
    logic           rst_n;
    logic           I_ap_start;
    logic           O_ap_done;
    logic           O_ap_idle;
    logic           O_ap_ready;
    logic           O_err;
    logic [AW-1:0]  I_base_addr;
    logic [RAW-1:0] I_ram_base;
    logic [CW-1:0]  I_len;
    logic [RAW-1:0] O_waddr;
    logic [DW-1:0]  O_wdata;
    logic           O_wr;
    logic [AW-1:0]  O_maxi_araddr;
    logic [LW-1:0]  O_maxi_arlen;
    logic [2:0]     O_maxi_arsize;
    logic [1:0]     O_maxi_arburst;
    logic           O_maxi_arvalid;
    logic           I_maxi_arready;
    logic [DW-1:0]  I_maxi_rdata;
    logic [1:0]     I_maxi_rresp;
    logic           I_maxi_rlast;
    logic           I_maxi_rvalid;
    logic           O_maxi_rready;

    axi_burst_rd2ram dut (
        .I_clk          (clk),
        .I_rst_n        (rst_n),
        .I_ap_start     (I_ap_start),
        .O_ap_done      (O_ap_done),
        .O_ap_idle      (O_ap_idle),
        .O_ap_ready     (O_ap_ready),
        .O_err          (O_err),
        .I_base_addr    (I_base_addr),
        .I_ram_base     (I_ram_base),
        .I_len          (I_len),
        .O_waddr        (O_waddr),
        .O_wdata        (O_wdata),
        .O_wr           (O_wr),
        .O_maxi_araddr  (O_maxi_araddr),
        .O_maxi_arlen   (O_maxi_arlen),
        .O_maxi_arsize  (O_maxi_arsize),
        .O_maxi_arburst (O_maxi_arburst),
        .O_maxi_arvalid (O_maxi_arvalid),
        .I_maxi_arready (I_maxi_arready),
        .I_maxi_rdata   (I_maxi_rdata),
        .I_maxi_rresp   (I_maxi_rresp),
        .I_maxi_rlast   (I_maxi_rlast),
        .I_maxi_rvalid  (I_maxi_rvalid),
        .O_maxi_rready  (O_maxi_rready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passed = 0;

    logic [RAW+DW-1:0] exp_q[$];     // expected RAM writes {waddr, wdata}
    logic [31:0]       exp_ba[$];    // expected burst addresses
    int                exp_bn[$];    // expected burst beat counts
    logic [31:0]       pend_a[$];    // bursts accepted by the slave, awaiting data
    int                pend_n[$];
    int                pend_b[$];
    logic [31:0]       obs_araddr[$];
    int                obs_arlen[$];
    int                obs_waddr[$];

    logic [RAW+DW-1:0] e_cmp;
    logic              prev_arv;
    logic [AW-1:0]     prev_araddr;
    logic [LW-1:0]     prev_arlen;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (O_wr) begin
                obs_waddr.push_back(int'(O_waddr));
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e_cmp = exp_q.pop_front();
                    check("waddr", O_waddr, e_cmp[RAW+DW-1:DW]);
                    check("wdata", O_wdata, e_cmp[DW-1:0]);
                end
            end
            // arready as sampled on the last edge: low means the request must still be held
            if (prev_arv && !I_maxi_arready) begin
                check("arvalid_held", O_maxi_arvalid, 1);
                check("araddr_stable", O_maxi_araddr, prev_araddr);
                check("arlen_stable", O_maxi_arlen, prev_arlen);
            end
            prev_arv    = O_maxi_arvalid;
            prev_araddr = O_maxi_araddr;
            prev_arlen  = O_maxi_arlen;
        end else begin
            prev_arv = 1'b0;
        end
    end

    // ---------------- model: burst plan ----------------
    task automatic build_bursts(input logic [31:0] base, input int len);
        logic [31:0] a;
        int rem;
        int page;
        int n;
        exp_ba.delete();
        exp_bn.delete();
        a   = base;
        rem = len;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / 16;
            n = rem;
            if (n > 16) n = 16;
            if (n > page) n = page;
            exp_ba.push_back(a);
            exp_bn.push_back(n);
            a   = a + 32'(n * 16);
            rem = rem - n;
        end
    endtask

    task automatic idle_inputs();
        I_ap_start     = 1'b0;
        I_maxi_arready = 1'b0;
        I_maxi_rvalid  = 1'b0;
        I_maxi_rlast   = 1'b0;
        I_maxi_rresp   = 2'b00;
        I_maxi_rdata   = '0;
    endtask

    // ---------------- driver: one transfer with a randomised slave ----------------
    // ekind: 0 none, 1 SLVERR on (eb,ej), 2 early rlast at (eb,ej), 3 rlast missing on burst eb
    task automatic run_xfer(input logic [31:0] base, input int rbase, input int len,
                            input int ekind, input int eb, input int ej, input int abort_c);
        int c;
        int done_cnt;
        int bnum;
        int rj;
        bit err_exp;
        bit r_off;
        bit fin;
        logic [31:0] off;
        logic [RAW-1:0] wa;
        logic [DW-1:0] d;

        build_bursts(base, len);
        pend_a.delete(); pend_n.delete(); pend_b.delete();
        obs_araddr.delete(); obs_arlen.delete(); obs_waddr.delete();
        exp_q.delete();

        @(negedge clk); #1;
        I_base_addr = base;
        I_ram_base  = RAW'(rbase);
        I_len       = CW'(len);
        I_ap_start  = 1'b1;
        I_maxi_arready = 1'b0;
        I_maxi_rvalid  = 1'b0;
        c = 0; done_cnt = 0; bnum = 0; rj = 0; r_off = 0; err_exp = 0; fin = 0;

        while (!fin) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check("busy_after_start", O_ap_idle, 0);
                check("err_cleared_on_start", O_err, 0);
            end
            if (O_ap_done) begin
                done_cnt++;
                check("ready_with_done", O_ap_ready, 1);
                check("err_at_done", O_err, err_exp);
                if (len == 0) check("len0_done_latency", c, 1);
                fin = 1;
            end
            #1;
            if (abort_c != 0 && c == abort_c) begin
                rst_n = 1'b0;
                #1;
                check("rst_idle", O_ap_idle, 1);
                check("rst_done", O_ap_done, 0);
                check("rst_wr", O_wr, 0);
                check("rst_waddr", O_waddr, 0);
                check("rst_wdata", O_wdata, 0);
                check("rst_arvalid", O_maxi_arvalid, 0);
                check("rst_araddr", O_maxi_araddr, 0);
                check("rst_arlen", O_maxi_arlen, 0);
                check("rst_rready", O_maxi_rready, 0);
                check("rst_err", O_err, 0);
                idle_inputs();
                exp_q.delete();
                pend_a.delete(); pend_n.delete(); pend_b.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (!fin && c > 5000) begin
                check("timeout", 0, 1);
                fin = 1;
            end
            if (fin) begin
                idle_inputs();
                if (done_cnt != 0) begin
                    check("writes_drained", exp_q.size(), 0);
                    check("bursts_all_issued", exp_ba.size(), 0);
                end
            end else begin
                I_maxi_arready = ($urandom_range(0, 2) != 0);
                if (!r_off) begin
                    if (pend_a.size() > 0 && $urandom_range(0, 3) != 0) begin
                        d = {$urandom, $urandom, $urandom, $urandom};
                        I_maxi_rdata = d;
                        I_maxi_rresp = (ekind == 1 && pend_b[0] == eb && rj == ej) ? 2'b10 : 2'b00;
                        if (ekind == 2 && pend_b[0] == eb && rj == ej)
                            I_maxi_rlast = 1'b1;
                        else if (ekind == 3 && pend_b[0] == eb)
                            I_maxi_rlast = 1'b0;
                        else
                            I_maxi_rlast = (rj == pend_n[0] - 1);
                        I_maxi_rvalid = 1'b1;
                        r_off = 1;
                    end else begin
                        I_maxi_rvalid = 1'b0;
                    end
                end
                #1;
                if (O_maxi_arvalid && I_maxi_arready) begin
                    obs_araddr.push_back(O_maxi_araddr);
                    obs_arlen.push_back(int'(O_maxi_arlen));
                    if (exp_ba.size() == 0) begin
                        check("ar_extra", 1, 0);
                    end else begin
                        check("araddr", O_maxi_araddr, exp_ba[0]);
                        check("arlen", O_maxi_arlen, exp_bn[0] - 1);
                        pend_a.push_back(exp_ba.pop_front());
                        pend_n.push_back(exp_bn.pop_front());
                        pend_b.push_back(bnum);
                        bnum++;
                    end
                end
                if (I_maxi_rvalid && O_maxi_rready && pend_a.size() > 0) begin
                    if (I_maxi_rresp != 2'b00) err_exp = 1;
                    if (I_maxi_rlast && rj != pend_n[0] - 1) err_exp = 1;
                    if (!I_maxi_rlast && rj == pend_n[0] - 1) err_exp = 1;
                    // RAM word = ram base + beat offset of this beat within the DDR run
                    off = (pend_a[0] - base) >> 4;
                    wa  = RAW'(off + 32'(rbase) + 32'(rj));
                    exp_q.push_back({wa, I_maxi_rdata});
                    rj++;
                    if (I_maxi_rlast || rj == pend_n[0]) begin
                        void'(pend_a.pop_front());
                        void'(pend_n.pop_front());
                        void'(pend_b.pop_front());
                        rj = 0;
                    end
                    r_off = 0;
                end
            end
        end

        repeat (3) begin
            @(negedge clk);
            if (O_ap_done) done_cnt++;
        end
        check("done_once", done_cnt, 1);
        check("idle_after", O_ap_idle, 1);
        check("err_sticky", O_err, err_exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] b;
        rst_n = 1'b0;
        I_base_addr = '0;
        I_ram_base  = '0;
        I_len       = '0;
        idle_inputs();
        prev_arv = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_idle", O_ap_idle, 1);
        check("reset_done", O_ap_done, 0);
        check("reset_ready", O_ap_ready, 0);
        check("reset_arvalid", O_maxi_arvalid, 0);
        check("reset_wr", O_wr, 0);
        check("reset_rready", O_maxi_rready, 0);
        check("reset_err", O_err, 0);
        check("arsize_const", O_maxi_arsize, 4);
        check("arburst_const", O_maxi_arburst, 1);
        rst_n = 1'b1;

        // 40 beats from a page start: three bursts 16/16/8
        run_xfer(32'h1000, 0, 40, 0, 0, 0, 0);
        check("t1_nbursts", obs_arlen.size(), 3);
        if (obs_arlen.size() == 3) begin
            check("t1_arlen0", obs_arlen[0], 15);
            check("t1_arlen1", obs_arlen[1], 15);
            check("t1_arlen2", obs_arlen[2], 7);
            check("t1_araddr1", obs_araddr[1], 32'h1100);
            check("t1_araddr2", obs_araddr[2], 32'h1200);
        end
        check("t1_nwrites", obs_waddr.size(), 40);
        if (obs_waddr.size() == 40) check("t1_last_waddr", obs_waddr[39], 39);

        // 4 KB split
        run_xfer(32'h0FF0, 0, 4, 0, 0, 0, 0);
        check("t2_nbursts", obs_arlen.size(), 2);
        if (obs_arlen.size() == 2) begin
            check("t2_arlen0", obs_arlen[0], 0);
            check("t2_araddr0", obs_araddr[0], 32'h0FF0);
            check("t2_arlen1", obs_arlen[1], 2);
            check("t2_araddr1", obs_araddr[1], 32'h1000);
        end

        // zero length
        run_xfer(32'h2000, 5, 0, 0, 0, 0, 0);
        check("t3_no_ar", obs_arlen.size(), 0);
        check("t3_no_wr", obs_waddr.size(), 0);

        // RAM address wrap
        run_xfer(32'h0000_8000, 1020, 8, 0, 0, 0, 0);
        check("t4_nwrites", obs_waddr.size(), 8);
        if (obs_waddr.size() == 8) begin
            check("t4_waddr3", obs_waddr[3], 1023);
            check("t4_waddr4", obs_waddr[4], 0);
        end

        // error cases
        run_xfer(32'h0000_2000, 7, 20, 1, 0, 3, 0);
        run_xfer(32'h0000_3000, 0, 40, 2, 1, 5, 0);
        run_xfer(32'h0000_4000, 200, 20, 3, 0, 0, 0);

        // reset mid-transfer, then a clean transfer
        run_xfer(32'h0000_5000, 0, 60, 0, 0, 0, 20);
        run_xfer(32'h0000_6000, 100, 30, 0, 0, 0, 0);

        // random transfers
        for (int k = 0; k < 10; k++) begin
            b = $urandom & 32'h00FF_FFF0;
            if (k % 3 == 0) b = {b[31:12], 12'hF80};
            run_xfer(b, $urandom_range(0, 1023), $urandom_range(0, 80),
                     (k % 4 == 1) ? 1 : 0, 0, $urandom_range(0, 3), 0);
        end

        // full RAM fill
        run_xfer(32'h0010_0000, 0, 1024, 0, 0, 0, 0);
        check("full_nwrites", obs_waddr.size(), 1024);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
